nrdiv_ctrl: RTL and testbench
=============================

Name: nrdiv_ctrl

Overview:
Sequencing controller for the 8-bit Newton-Raphson divider datapath (nrdiv). It drives that datapath's mux selects and register load strobes to run ITER refinement iterations of the reciprocal approximation, then a final multiply by x. It captures the quotient and reports completion through a start/busy/done handshake. It sits directly upstream of nrdiv. All nrdiv control inputs come from this block.

Parameters:
ITER, 2, number of NR iterations; legal range 1..15; an elaboration-time check rejects any other value.

Ports:
clk  input  1  system clock; all state changes on the rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request a division; sampled only in IDLE
q_in  input  8  nrdiv q (rne_out) result bus
sel_muxd  output  1  0 = x, 1 = d into muxb path
sel_muxa  output  1  1 = initial approximation, 0 = rega_out
sel_muxb  output  1  0 = muxd_out, 1 = regb_out
load_rega  output  1  one-cycle strobe that loads rega
load_regb  output  1  one-cycle strobe that loads regb
busy  output  1  high while a division is in progress
done  output  1  one-cycle pulse when q_out is valid
q_out  output  8  captured quotient; held until the next capture

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, port reset.
- Reset values:
  - state = IDLE, iter counter = 0.
  - All selects, loads, busy and done = 0.
  - q_out = 8'h00.
- Reset mid-operation: everything returns to reset values immediately, and loads drop without waiting for an edge.
- Registered outputs: every control output comes straight from a flop, computed from next-state. Load strobes must be glitch-free, because nrdiv registers may use them as capture edges.
- Step structure: each datapath step takes 2 cycles.
  - SETUP: selects driven, loads low, so the multiplier path settles.
  - LOAD: selects unchanged, one strobe high.
- States and outputs (unlisted outputs = 0):
  - IDLE: start=1 -> D_SETUP, counter cleared. start=0 -> stay.
  - D_SETUP / D_LOAD: sel_muxd=1, sel_muxb=0, sel_muxa=(iter==0). load_regb=1 in D_LOAD only. The datapath then holds regb = 2 - a*d.
  - R_SETUP / R_LOAD: sel_muxd=1, sel_muxb=1, sel_muxa=(iter==0). load_rega=1 in R_LOAD only. The datapath then holds rega = a*(2 - a*d).
  - On leaving R_LOAD: counter increments. If the new count == ITER -> X_SETUP, else -> D_SETUP.
  - X_SETUP / X_CAPT: sel_muxa=0, sel_muxb=0, sel_muxd=0 (rega*x). On the X_CAPT edge, q_out <= q_in.
  - DONE: done=1, busy=0 -> IDLE next cycle.
- Busy: 1 in every state except IDLE and DONE.
- Latency: start sampled at edge 0.
  - busy high for cycles 1..4*ITER+2.
  - done high in cycle 4*ITER+3. For ITER=2 that is cycle 11.
- start handling: ignored while busy and in DONE; no queueing. Back-to-back divisions need start re-asserted in IDLE.
- Counter: 4 bits wide. It never wraps, because ITER <= 15.
- q_out changes only in the X_CAPT transition. It keeps its value through later IDLE periods.

Decomposition:
- Shared package nrdiv_pkg:
  - state enum (IDLE, D_SETUP, D_LOAD, R_SETUP, R_LOAD, X_SETUP, X_CAPT, DONE);
  - default iteration constant (2);
  - counter width (4).
- No sub-module: the FSM, counter and capture register stay in one module.

Test Plan:
- Reset: assert reset mid-cycle while idle -> all outputs 0 and q_out=8'h00 immediately, without waiting for a clk edge.
- Nominal ITER=2: start pulse at cycle 0 -> in cycles 1..10 the sequence is:
  - sel_muxa=1 in cycles 1..4, then 0;
  - load_regb in cycles 2 and 6;
  - load_rega in cycles 4 and 8;
  - sel_muxd=0 in cycles 9..10.
  Bench drives q_in=8'hA5 in cycle 10 -> q_out=8'hA5 and done=1 in cycle 11; busy=0 from cycle 11.
- ITER=1: start -> exactly one load_regb and one load_rega strobe, both with sel_muxa=1; done in cycle 7.
- start held high continuously -> start is ignored while busy and in DONE. A new division begins only after IDLE is reached: done in cycle 11, IDLE in cycle 12, next done in cycle 23. q_out updates once per division.
- Reset asserted during R_LOAD -> load_rega drops asynchronously, state returns to IDLE, and no done pulse occurs. A subsequent start gives a full-length sequence.
- Integration with nrdiv (ITER=2) -> q_out equals the bench's bit-accurate model of the same recurrence, applied with rne rounding at each step, for d in {8'h40, 8'h60, 8'hC0} and x=8'h30.

Source files
------------

// File: rtl/nrdiv_pkg.sv
// Shared types and constants for the Newton-Raphson divider sequencer.
// The control decode maps a state and iteration count onto the datapath control word.
package nrdiv_pkg;

  localparam int ITER_DEFAULT = 2;
  localparam int CNT_W        = 4;

  typedef enum logic [2:0] {
    IDLE,
    D_SETUP,
    D_LOAD,
    R_SETUP,
    R_LOAD,
    X_SETUP,
    X_CAPT,
    DONE
  } state_t;

  typedef struct packed {
    logic sel_muxd;
    logic sel_muxa;
    logic sel_muxb;
    logic load_rega;
    logic load_regb;
    logic busy;
    logic done;
  } ctrl_t;

  // The first refinement step feeds the initial approximation instead of rega.
  function automatic ctrl_t ctrl_decode(input state_t state, input logic [CNT_W-1:0] cnt);
    ctrl_t c;
    c = '0;
    case (state)
      D_SETUP, D_LOAD: begin
        c.sel_muxd  = 1'b1;
        c.sel_muxa  = (cnt == '0);
        c.load_regb = (state == D_LOAD);
        c.busy      = 1'b1;
      end
      R_SETUP, R_LOAD: begin
        c.sel_muxd  = 1'b1;
        c.sel_muxb  = 1'b1;
        c.sel_muxa  = (cnt == '0);
        c.load_rega = (state == R_LOAD);
        c.busy      = 1'b1;
      end
      X_SETUP, X_CAPT: c.busy = 1'b1;
      DONE:            c.done = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/nrdiv_ctrl.sv
// Sequencer for the nrdiv datapath: ITER reciprocal refinements, a final multiply by x,
// and quotient capture behind a start/busy/done handshake.
module nrdiv_ctrl
  import nrdiv_pkg::*;
#(
  parameter int ITER = ITER_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] q_in,
  output logic       sel_muxd,
  output logic       sel_muxa,
  output logic       sel_muxb,
  output logic       load_rega,
  output logic       load_regb,
  output logic       busy,
  output logic       done,
  output logic [7:0] q_out
);

  if (ITER < 1 || ITER > 15) begin : g_iter_check
    $error("nrdiv_ctrl: ITER must be in the range 1..15");
  end

  localparam logic [CNT_W-1:0] ITER_CNT = CNT_W'(ITER);

  state_t           r_state, w_next_state;
  logic [CNT_W-1:0] r_cnt, w_next_cnt;
  ctrl_t            r_ctrl, w_next_ctrl;
  logic [7:0]       r_q;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next_state = D_SETUP;
          w_next_cnt   = '0;
        end
      end
      D_SETUP: w_next_state = D_LOAD;
      D_LOAD:  w_next_state = R_SETUP;
      R_SETUP: w_next_state = R_LOAD;
      R_LOAD: begin
        w_next_cnt   = r_cnt + 1'b1;
        w_next_state = (w_next_cnt == ITER_CNT) ? X_SETUP : D_SETUP;
      end
      X_SETUP: w_next_state = X_CAPT;
      X_CAPT:  w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
    // Outputs are decoded from the upcoming state so they can be registered glitch-free.
    w_next_ctrl = ctrl_decode(w_next_state, w_next_cnt);
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ctrl  <= '0;
      r_q     <= 8'h00;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      r_ctrl  <= w_next_ctrl;
      if (r_state == X_CAPT) r_q <= q_in;
    end
  end

  assign sel_muxd  = r_ctrl.sel_muxd;
  assign sel_muxa  = r_ctrl.sel_muxa;
  assign sel_muxb  = r_ctrl.sel_muxb;
  assign load_rega = r_ctrl.load_rega;
  assign load_regb = r_ctrl.load_regb;
  assign busy      = r_ctrl.busy;
  assign done      = r_ctrl.done;
  assign q_out     = r_q;

endmodule

// File: tb/tb_nrdiv_ctrl.sv
// Self-checking bench: an ITER=2 and an ITER=1 controller, a behavioural nrdiv datapath
// for the ITER=2 instance, and a quotient scoreboard consumed on each done pulse.
module tb_nrdiv_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset = 1'b0;
  logic [1:0]      start = 2'b00;
  logic [1:0][7:0] q_in;
  logic [1:0]      sel_muxd, sel_muxa, sel_muxb, load_rega, load_regb, busy, done;
  logic [1:0][7:0] q_out;

  logic [7:0] q_drv0 = 8'h00;
  logic [7:0] q_drv1 = 8'h00;
  logic       use_model = 1'b0;

  int n_pass  = 0;
  int n_total = 0;
  logic [7:0] sb_q[$];

  nrdiv_ctrl #(.ITER(2)) dut2 (
    .clk(clk), .reset(reset), .start(start[0]), .q_in(q_in[0]),
    .sel_muxd(sel_muxd[0]), .sel_muxa(sel_muxa[0]), .sel_muxb(sel_muxb[0]),
    .load_rega(load_rega[0]), .load_regb(load_regb[0]),
    .busy(busy[0]), .done(done[0]), .q_out(q_out[0])
  );

  nrdiv_ctrl #(.ITER(1)) dut1 (
    .clk(clk), .reset(reset), .start(start[1]), .q_in(q_in[1]),
    .sel_muxd(sel_muxd[1]), .sel_muxa(sel_muxa[1]), .sel_muxb(sel_muxb[1]),
    .load_rega(load_rega[1]), .load_regb(load_regb[1]),
    .busy(busy[1]), .done(done[1]), .q_out(q_out[1])
  );

  // Datapath model, Q2.6 unsigned: 2.0 = 128, initial approximation 0.5.
  localparam logic [7:0] A0  = 8'h20;
  localparam logic [7:0] TWO = 8'h80;

  function automatic logic [7:0] mul_rne(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    logic [9:0]  q;
    p = a * b;
    q = p[15:6];
    if (p[5] && ((p[4:0] != 5'd0) || q[0])) q = q + 10'd1;
    return (q > 10'd255) ? 8'hFF : q[7:0];
  endfunction

  function automatic logic [7:0] sub2(input logic [7:0] p);
    return (p >= TWO) ? 8'h00 : TWO - p;
  endfunction

  function automatic logic [7:0] ref_div(input logic [7:0] d, input logic [7:0] x, input int iters);
    logic [7:0] a, b;
    a = A0;
    for (int i = 0; i < iters; i++) begin
      b = sub2(mul_rne(a, d));
      a = mul_rne(a, b);
    end
    return mul_rne(a, x);
  endfunction

  logic [7:0] dp_d = 8'h00, dp_x = 8'h00, dp_rega = 8'h00, dp_regb = 8'h00;
  logic [7:0] dp_muxd, dp_muxa, dp_muxb, dp_prod;

  always_comb begin
    dp_muxd = sel_muxd[0] ? dp_d : dp_x;
    dp_muxa = sel_muxa[0] ? A0 : dp_rega;
    dp_muxb = sel_muxb[0] ? dp_regb : dp_muxd;
    dp_prod = mul_rne(dp_muxa, dp_muxb);
  end

  always @(posedge clk) begin
    if (load_regb[0]) dp_regb <= sub2(dp_prod);
    if (load_rega[0]) dp_rega <= dp_prod;
  end

  assign q_in[0] = use_model ? dp_prod : q_drv0;
  assign q_in[1] = q_drv1;

  // Control word {sel_muxd, sel_muxa, sel_muxb, load_rega, load_regb, busy, done}.
  function automatic logic [6:0] ctl(input int i);
    return {sel_muxd[i], sel_muxa[i], sel_muxb[i], load_rega[i], load_regb[i], busy[i], done[i]};
  endfunction

  // Expected control word in cycle c after a start sampled at edge 0.
  function automatic logic [6:0] exp_ctl(input int iters, input int c);
    logic [6:0] v;
    int k;
    v = '0;
    if (c >= 1 && c <= 4 * iters) begin
      k    = (c - 1) % 4;
      v[6] = 1'b1;
      v[5] = (c <= 4);
      v[4] = (k >= 2);
      v[3] = (k == 3);
      v[2] = (k == 1);
      v[1] = 1'b1;
    end else if (c == 4 * iters + 1 || c == 4 * iters + 2) begin
      v[1] = 1'b1;
    end else if (c == 4 * iters + 3) begin
      v[0] = 1'b1;
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    reset = 1'b1;
    #1;
    n_total++;
    if ({ctl(0), ctl(1)} !== 14'h0) $display("FAIL reset_ctl: got %b want 0", {ctl(0), ctl(1)});
    else n_pass++;
    n_total++;
    if (q_out !== 16'h0) $display("FAIL reset_q: got %h want 0000", q_out);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    tick();
    n_total++;
    if ({ctl(0), ctl(1)} !== 14'h0) $display("FAIL idle_after_reset: got %b want 0", {ctl(0), ctl(1)});
    else n_pass++;
  endtask

  task automatic test_nominal();
    logic [7:0] e;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      n_total++;
      if (ctl(0) !== exp_ctl(2, c)) $display("FAIL nominal_ctl cycle %0d: got %b want %b", c, ctl(0), exp_ctl(2, c));
      else n_pass++;
      if (done[0] && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_total++;
        if (q_out[0] !== e) $display("FAIL nominal_q cycle %0d: got %h want %h", c, q_out[0], e);
        else n_pass++;
      end
      if (c == 10) begin
        q_drv0 = 8'hA5;
        sb_q.push_back(8'hA5);
      end
      if (c < 12) tick();
    end
    n_total++;
    if (sb_q.size() != 0) begin
      $display("FAIL nominal_sb: got %0d pending want 0", sb_q.size());
      sb_q.delete();
    end else n_pass++;
  endtask

  task automatic test_iter1();
    int nb, na, bad;
    logic [7:0] e;
    nb = 0; na = 0; bad = 0;
    start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      n_total++;
      if (ctl(1) !== exp_ctl(1, c)) $display("FAIL iter1_ctl cycle %0d: got %b want %b", c, ctl(1), exp_ctl(1, c));
      else n_pass++;
      if (load_regb[1]) nb++;
      if (load_rega[1]) na++;
      if ((load_regb[1] || load_rega[1]) && !sel_muxa[1]) bad++;
      if (done[1] && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_total++;
        if (q_out[1] !== e) $display("FAIL iter1_q cycle %0d: got %h want %h", c, q_out[1], e);
        else n_pass++;
      end
      if (c == 6) begin
        q_drv1 = 8'h77;
        sb_q.push_back(8'h77);
      end
      if (c < 8) tick();
    end
    n_total++;
    if (nb != 1 || na != 1 || bad != 0) $display("FAIL iter1_strobes: got regb=%0d rega=%0d bad=%0d want 1 1 0", nb, na, bad);
    else n_pass++;
    sb_q.delete();
  endtask

  task automatic test_back_to_back();
    int n_done;
    logic [7:0] e;
    n_done = 0;
    q_drv0   = 8'h3C;
    sb_q.push_back(8'h3C);
    start[0] = 1'b1;
    tick();
    for (int c = 1; c <= 24; c++) begin
      n_total++;
      if (ctl(0) !== exp_ctl(2, (c <= 12) ? c : c - 12))
        $display("FAIL b2b_ctl cycle %0d: got %b want %b", c, ctl(0), exp_ctl(2, (c <= 12) ? c : c - 12));
      else n_pass++;
      if (done[0]) begin
        n_done++;
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          n_total++;
          if (q_out[0] !== e) $display("FAIL b2b_q cycle %0d: got %h want %h", c, q_out[0], e);
          else n_pass++;
        end
        if (c == 11) begin
          q_drv0 = 8'h5A;
          sb_q.push_back(8'h5A);
        end
      end
      if (c == 22) begin
        n_total++;
        if (q_out[0] !== 8'h3C) $display("FAIL b2b_hold cycle %0d: got %h want 3c", c, q_out[0]);
        else n_pass++;
      end
      if (c == 24) start[0] = 1'b0;
      else tick();
    end
    tick();
    n_total++;
    if (n_done != 2 || busy[0] !== 1'b0) $display("FAIL b2b_count: got done=%0d busy=%b want 2 0", n_done, busy[0]);
    else n_pass++;
    sb_q.delete();
  endtask

  task automatic test_reset_mid_op();
    int n_done;
    logic [7:0] e;
    n_done = 0;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    tick(); tick(); tick();
    n_total++;
    if (load_rega[0] !== 1'b1) $display("FAIL mid_rload: got %b want 1", load_rega[0]);
    else n_pass++;
    #2;
    reset = 1'b1;
    #1;
    n_total++;
    if (ctl(0) !== 7'h0 || q_out[0] !== 8'h00) $display("FAIL mid_reset: got %b q=%h want 0 q=00", ctl(0), q_out[0]);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (done[0] || busy[0]) n_done++;
    end
    n_total++;
    if (n_done != 0) $display("FAIL mid_no_done: got %0d active cycles want 0", n_done);
    else n_pass++;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      n_total++;
      if (ctl(0) !== exp_ctl(2, c)) $display("FAIL mid_restart_ctl cycle %0d: got %b want %b", c, ctl(0), exp_ctl(2, c));
      else n_pass++;
      if (done[0] && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_total++;
        if (q_out[0] !== e) $display("FAIL mid_restart_q: got %h want %h", q_out[0], e);
        else n_pass++;
      end
      if (c == 10) begin
        q_drv0 = 8'h11;
        sb_q.push_back(8'h11);
      end
      if (c < 11) tick();
    end
    tick();
    sb_q.delete();
  endtask

  task automatic test_integration();
    logic [7:0] d_list[3];
    logic [7:0] e;
    int cyc;
    d_list[0] = 8'h40; d_list[1] = 8'h60; d_list[2] = 8'hC0;
    use_model = 1'b1;
    dp_x      = 8'h30;
    for (int k = 0; k < 3; k++) begin
      dp_d = d_list[k];
      sb_q.push_back(ref_div(d_list[k], 8'h30, 2));
      start[0] = 1'b1;
      tick();
      start[0] = 1'b0;
      cyc = 1;
      while (!done[0] && cyc < 20) begin
        tick();
        cyc++;
      end
      e = sb_q.pop_front();
      n_total++;
      if (!done[0]) $display("FAIL integ_timeout d=%h: no done within 20 cycles", d_list[k]);
      else if (cyc != 11 || q_out[0] !== e)
        $display("FAIL integ d=%h: got q=%h at cycle %0d want q=%h at cycle 11", d_list[k], q_out[0], cyc, e);
      else n_pass++;
      tick();
    end
    use_model = 1'b0;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_iter1();
    test_back_to_back();
    test_reset_mid_op();
    test_integration();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
